// File: rtl/avmm_burst_master_if.sv
// Avalon-MM burst bus bundle shared by the burst initiator and its register slaves.
interface avmm_if #(
  parameter int AW  = 16,
  parameter int DW  = 64,
  parameter int BCW = 4
);
  logic [AW-1:0]  address;
  logic           read;
  logic           write;
  logic [DW-1:0]  writedata;
  logic [BCW-1:0] burstcount;
  logic           waitrequest;
  logic [DW-1:0]  readdata;
  logic           readdatavalid;

  modport master (
    output address, read, write, writedata, burstcount,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, burstcount,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/avmm_burst_master.sv
// Avalon-MM burst initiator: one read or write burst per command, with
// length checking and a stall timeout that aborts a hung burst.
module avmm_burst_master #(
  parameter int AW        = 16,
  parameter int DW        = 64,
  parameter int MAX_BURST = 8,
  parameter int BCW       = $clog2(MAX_BURST) + 1,
  parameter int TIMEOUT   = 1024
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_write,
  input  logic [AW-1:0]  cmd_addr,
  input  logic [BCW-1:0] cmd_len,
  input  logic [DW-1:0]  wr_data,
  input  logic           wr_valid,
  output logic           wr_ready,
  output logic [DW-1:0]  rd_data,
  output logic           rd_valid,
  output logic           done,
  output logic           error,
  avmm_if.master         bus
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [BCW-1:0] LEN_MAX  = BCW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_CMD  = 2'd2,
    RD_DATA = 2'd3
  } state_t;

  state_t         state_r, state_s;
  logic [AW-1:0]  addr_r, addr_s;
  logic [BCW-1:0] len_r, len_s;
  logic [BCW-1:0] beat_r, beat_s;
  logic [TW-1:0]  tmo_r, tmo_s;
  logic [DW-1:0]  rd_data_r, rd_data_s;
  logic           rd_valid_r, rd_valid_s;
  logic           done_r, done_s;
  logic           error_r, error_s;
  logic           bus_read_s, bus_write_s, wr_ready_s;
  logic           tmo_hit_s, last_beat_s;

  // Next-state, bus strobes and counter updates; a timeout takes priority over any beat.
  always_comb begin
    state_s     = state_r;
    addr_s      = addr_r;
    len_s       = len_r;
    beat_s      = beat_r;
    tmo_s       = tmo_r;
    rd_data_s   = rd_data_r;
    rd_valid_s  = 1'b0;
    done_s      = 1'b0;
    error_s     = 1'b0;
    bus_read_s  = 1'b0;
    bus_write_s = 1'b0;
    wr_ready_s  = 1'b0;
    tmo_hit_s   = (tmo_r == TMO_LAST);
    last_beat_s = (beat_r == (len_r - BCW'(1)));
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          if ((cmd_len == BCW'(0)) || (cmd_len > LEN_MAX)) begin
            error_s = 1'b1;
          end else begin
            addr_s  = cmd_addr;
            len_s   = cmd_len;
            beat_s  = BCW'(0);
            tmo_s   = TW'(0);
            state_s = cmd_write ? WR : RD_CMD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WR: begin
        if (tmo_hit_s) begin
          state_s = IDLE;
          error_s = 1'b1;
        end else begin
          bus_write_s = wr_valid;
          wr_ready_s  = wr_valid && !bus.waitrequest;
          if (wr_ready_s) begin
            tmo_s  = TW'(0);
            beat_s = beat_r + BCW'(1);
            if (last_beat_s) begin
              state_s = IDLE;
              done_s  = 1'b1;
            end else begin
              state_s = WR;
            end
          end else begin
            tmo_s = tmo_r + TW'(1);
          end
        end
      end
      RD_CMD: begin
        if (tmo_hit_s) begin
          state_s = IDLE;
          error_s = 1'b1;
        end else begin
          bus_read_s = 1'b1;
          if (!bus.waitrequest) begin
            tmo_s   = TW'(0);
            state_s = RD_DATA;
          end else begin
            tmo_s = tmo_r + TW'(1);
          end
        end
      end
      RD_DATA: begin
        if (tmo_hit_s) begin
          state_s = IDLE;
          error_s = 1'b1;
        end else if (bus.readdatavalid) begin
          rd_valid_s = 1'b1;
          rd_data_s  = bus.readdata;
          tmo_s      = TW'(0);
          beat_s     = beat_r + BCW'(1);
          if (last_beat_s) begin
            state_s = IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = RD_DATA;
          end
        end else begin
          tmo_s = tmo_r + TW'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      addr_r     <= '0;
      len_r      <= '0;
      beat_r     <= '0;
      tmo_r      <= '0;
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      addr_r     <= addr_s;
      len_r      <= len_s;
      beat_r     <= beat_s;
      tmo_r      <= tmo_s;
      rd_data_r  <= rd_data_s;
      rd_valid_r <= rd_valid_s;
      done_r     <= done_s;
      error_r    <= error_s;
    end
  end

  assign cmd_ready      = (state_r == IDLE);
  assign wr_ready       = wr_ready_s;
  assign rd_data        = rd_data_r;
  assign rd_valid       = rd_valid_r;
  assign done           = done_r;
  assign error          = error_r;
  assign bus.address    = addr_r;
  assign bus.burstcount = len_r;
  assign bus.read       = bus_read_s;
  assign bus.write      = bus_write_s;
  assign bus.writedata  = wr_data;

endmodule

// File: doc/avmm_burst_master.md
Name: avmm_burst_master

Overview:
- Avalon-MM initiator: the requesting end of the burst bus used by our register slaves such as the page/control register block.
- Accepts one read or write burst command at a time from local logic and drives a standard `avmm_if.master` port.
- Write beats are pulled from a valid/ready stream; read beats are returned on a registered valid stream.
- Reports completion with `done` and reports rejects or timeouts with `error`.

Parameters:
- AW, 16, address width.
- DW, 64, data width.
- MAX_BURST, 8, maximum beats per burst.
- BCW, $clog2(MAX_BURST)+1, burst count width.
- TIMEOUT, 1024, stall cycles before abort; must be at least 2.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high in IDLE only; a command is taken when cmd_valid && cmd_ready.
- cmd_write  input  1  1 = write burst, 0 = read burst.
- cmd_addr  input  AW  burst start address.
- cmd_len  input  BCW  beats in the burst; legal range 1..MAX_BURST.
- wr_data  input  DW  write beat data.
- wr_valid  input  1  write beat available.
- wr_ready  output  1  write beat consumed this cycle.
- rd_data  output  DW  read beat data, registered.
- rd_valid  output  1  one-cycle strobe per read beat.
- done  output  1  one-cycle pulse when a burst completes.
- error  output  1  one-cycle pulse on command reject or timeout.
- bus  interface  avmm_if.master  uses address, read, write, writedata, burstcount, waitrequest, readdata, readdatavalid.

Behaviour:
- Reset values: state IDLE; bus.read = 0; bus.write = 0; bus.address = 0; bus.burstcount = 0; rd_valid = 0; done = 0; error = 0; rd_data = 0; all counters 0.
- Reset takes effect immediately, including mid-burst, and does not wait for a clock edge.
- States: IDLE, WR, RD_CMD, RD_DATA.
- IDLE: cmd_ready = 1.
  - On accept with cmd_len == 0 or cmd_len > MAX_BURST: error pulses in the next cycle, state stays IDLE, no bus activity.
  - On accept of a legal command: latch addr and len, clear beat counter and timeout counter.
  - Next state is WR if cmd_write, otherwise RD_CMD.
- bus.address and bus.burstcount hold the latched values for the whole burst; address does not increment per beat.
- WR:
  - bus.write = wr_valid; bus.writedata = wr_data.
  - wr_ready = wr_valid && !bus.waitrequest. A beat is accepted when bus.write && !bus.waitrequest.
  - The beat counter increments on each accepted beat.
  - On the last accepted beat: next state IDLE, done pulses the following cycle.
  - wr_valid may drop mid-burst; bus.write follows it combinationally.
- RD_CMD: bus.read = 1 until !bus.waitrequest, then go to RD_DATA. Exactly one read command is issued per burst.
- RD_DATA:
  - bus.read = 0.
  - Each cycle with bus.readdatavalid: rd_data <= bus.readdata and rd_valid <= 1 (one-cycle latency); counter increments.
  - On the last beat: go to IDLE; done pulses in the same cycle as the final rd_valid.
- bus.readdatavalid outside RD_DATA is ignored.
- Timeout counter:
  - Active in WR, RD_CMD and RD_DATA.
  - Clears on every accepted write beat, read command acceptance, or readdatavalid; increments otherwise.
  - When it reaches TIMEOUT-1: deassert read/write, go to IDLE, error pulses the next cycle, done does not pulse.
- Completion and next command: cmd_ready is high in the cycle done pulses, so a pending cmd_valid is accepted then (back-to-back, no bubble beyond one cycle).
- Counter width BCW; beat compare is against latched len-1. No wrap is possible for legal lengths.

Test Plan:
- Write, addr 0x10, len 4, data 0x1..0x4; slave waitrequest high 2 cycles on beat 2 -> 4 beats accepted in order, address 0x10 and burstcount 4 steady throughout, wr_ready pulses 4 times, single done.
- Read, addr 0x00, len 3; slave gives readdatavalid with 0xA, then a 1-cycle gap, 0xB, 0xC -> rd_valid 3 times, each 1 cycle after its beat, data A, B, C; done coincident with C.
- cmd_len = 0, then cmd_len = 9 (MAX_BURST = 8) -> error pulse each time, bus.read and bus.write stay 0, cmd_ready stays 1.
- TIMEOUT = 16, read len 2, slave never returns data -> error 16 cycles after RD_DATA entry, no done, cmd_ready = 1.
- Reset asserted between clock edges after 2 of 4 write beats -> bus.write = 0 and cmd_ready = 1 immediately; a new read command then completes normally.
- cmd_valid held high with write len 1 then read len 1 -> second command accepted in the done cycle of the first.
